// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port; data wins except when fetch has been starved.
// Latency: grant -> m_req next cycle, ack the cycle after m_ready (3 cycles minimum), timeout after TIMEOUT busy cycles.
// Backpressure: requesters hold req until their one-cycle ack; memory stalls via m_ready, bounded by the timeout.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state, state_nxt;
    logic        owner_d;
    logic [3:0]  streak;
    logic [7:0]  tcnt;
    logic        grant_d, grant_f, tout;

    always_comb begin
        grant_d   = d_req && !(if_req && (streak == 4'(STARVE_LIMIT)));
        grant_f   = if_req && !grant_d;
        // A completion on the last allowed cycle wins over the timeout.
        tout      = !m_ready && (tcnt == 8'(TIMEOUT - 1));
        state_nxt = state;
        case (state)
            IDLE:    if (grant_d || grant_f) state_nxt = BUSY;
            BUSY:    if (m_ready || tout)    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_d  <= 1'b0;
            streak   <= 4'd0;
            tcnt     <= 8'd0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= 32'd0;
            m_wdata  <= 32'd0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            if_rdata <= 32'd0;
            d_rdata  <= 32'd0;
            err      <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    tcnt <= 8'd0;
                    if (grant_d) begin
                        owner_d <= 1'b1;
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        streak  <= if_req ? streak + 4'd1 : 4'd0;
                    end else if (grant_f) begin
                        owner_d <= 1'b0;
                        m_req   <= 1'b1;
                        m_we    <= 1'b0;
                        m_addr  <= if_addr;
                        m_wdata <= 32'd0;
                        streak  <= 4'd0;
                    end
                end
                BUSY: begin
                    if (m_ready || tout) begin
                        m_req <= 1'b0;
                        if (!m_ready) err <= 1'b1;
                        // Stores and timeouts both return zero to the owner.
                        if (owner_d) begin
                            d_ack   <= 1'b1;
                            d_rdata <= (m_ready && !m_we) ? m_rdata : 32'd0;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= m_ready ? m_rdata : 32'd0;
                        end
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
